// File: rtl/amplificador.sv
// amplificador: registered 3-segment thermometer gain/level driver.
// The asynchronous gain code {A,B} is synchronised into the clk domain,
// registered as the target level, and shown on {S2,S1,S0} as a
// thermometer code (0->000, 1->001, 2->011, 3->111).
// Optional feature macro: AMPLIFICADOR_RAMP_EN. When it is defined, the level
// walks toward the target one step every RAMP_DIV cycles. When it is not
// defined, the level follows the target on every cycle and RAMP_DIV is ignored.
module amplificador #(
    parameter int SYNC_STAGES = 2,  // flops per input synchroniser, 2..4
    parameter int RAMP_DIV    = 4   // cycles per level step with ramp, 1..255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic A,
    input  logic B,
    output logic S0,
    output logic S1,
    output logic S2
);

    // Reject illegal configurations at elaboration time.
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || RAMP_DIV < 1 || RAMP_DIV > 255) begin : g_bad_param
        $error("amplificador: SYNC_STAGES must be 2..4 and RAMP_DIV must be 1..255");
    end

    // Thermometer encoding of a 2-bit level as {S2,S1,S0}.
    function automatic logic [2:0] therm(input logic [1:0] lvl);
        logic [2:0] t;
        t = 3'b000;
        case (lvl)
            2'd0: t = 3'b000;
            2'd1: t = 3'b001;
            2'd2: t = 3'b011;
            2'd3: t = 3'b111;
            default: t = 3'b000;
        endcase
        return t;
    endfunction

    logic [SYNC_STAGES-1:0] a_sync_q;
    logic [SYNC_STAGES-1:0] b_sync_q;
    logic [1:0]             target_q;
    logic [2:0]             seg_q;
    logic [2:0]             seg_d;

    // Input synchronisers: each input shifts through its own flop chain.
    // NOTE: all clocked state uses non-blocking assignments, so every flop
    // samples the value its neighbour held before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sync_q <= '0;
            b_sync_q <= '0;
        end else begin
            a_sync_q <= {a_sync_q[SYNC_STAGES-2:0], A};
            b_sync_q <= {b_sync_q[SYNC_STAGES-2:0], B};
        end
    end

    // Target register: the synchronised gain code, registered once more.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_q <= 2'd0;
        end else begin
            target_q <= {a_sync_q[SYNC_STAGES-1], b_sync_q[SYNC_STAGES-1]};
        end
    end

`ifdef AMPLIFICADOR_RAMP_EN
    localparam logic [7:0] RAMP_LAST = 8'(RAMP_DIV - 1);

    logic [1:0] level_q;
    logic [1:0] level_d;
    logic [7:0] pre_q;
    logic [7:0] pre_d;

    // Ramp step logic: the prescaler runs only while level and target differ.
    // Direction is re-evaluated every cycle, so a target change mid-ramp
    // keeps the running count.
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        level_d = level_q;
        pre_d   = 8'd0;
        if (level_q != target_q) begin
            if (pre_q == RAMP_LAST) begin
                pre_d   = 8'd0;
                level_d = (target_q > level_q) ? level_q + 2'd1 : level_q - 2'd1;
            end else begin
                pre_d = pre_q + 8'd1;
            end
        end
    end

    // Level and prescaler registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 2'd0;
            pre_q   <= 8'd0;
        end else begin
            level_q <= level_d;
            pre_q   <= pre_d;
        end
    end

    // Outputs are a registered decode of the ramped level.
    always_comb begin
        seg_d = therm(level_q);
    end
`else
    // Without the ramp, the level equals the target. seg_q is then the level
    // register itself, held in thermometer form.
    always_comb begin
        seg_d = therm(target_q);
    end
`endif

    // Output register: S0..S2 always come directly from flops, so a decode
    // glitch can never reach the amplifier enables.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= 3'b000;
        end else begin
            seg_q <= seg_d;
        end
    end

    assign S0 = seg_q[0];
    assign S1 = seg_q[1];
    assign S2 = seg_q[2];

endmodule

// File: tb/tb_amplificador.sv
// Directed testbench for amplificador (default parameters, 10 ns clock).
// Inputs change on the falling edge, and outputs are sampled on the falling edge.
// This places every sample half a cycle after a rising edge. At the k-th
// falling edge after a change, k rising edges have gone by.
// Compile with AMPLIFICADOR_RAMP_EN defined to exercise the soft ramp.
module tb_amplificador;

    logic clk = 1'b0;
    logic rst_n;
    logic A;
    logic B;
    logic S0;
    logic S1;
    logic S2;
    logic [2:0] seg;

    int n_checks = 0;
    int n_fail   = 0;

    amplificador dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .S0    (S0),
        .S1    (S1),
        .S2    (S2)
    );

    always #5 clk = ~clk;

    assign seg = {S2, S1, S0};

    task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got {S2,S1,S0}=%b, expected %b (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Ramp-off window: the old code is shown until the 4th edge, then the new code.
    task automatic step_window(input string tag, input int n,
                               input logic [2:0] old_v, input logic [2:0] new_v);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            check($sformatf("%s k=%0d", tag, k), seg, (k < 4) ? old_v : new_v);
        end
    endtask

    // Ramp-on window with RAMP_DIV=4: the code moves at edges 8, 12 and 16.
    task automatic ramp_window(input string tag, input int n,
                               input logic [2:0] v0, input logic [2:0] v1,
                               input logic [2:0] v2, input logic [2:0] v3);
        logic [2:0] e;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            e = (k < 8) ? v0 : (k < 12) ? v1 : (k < 16) ? v2 : v3;
            check($sformatf("%s k=%0d", tag, k), seg, e);
        end
    endtask

    initial begin
        // Test 1: reset held with A=B=1. The outputs must be 000 right away,
        // before any clock edge, and must stay 000 while reset is low.
        rst_n = 1'b0;
        A     = 1'b1;
        B     = 1'b1;
        #2;
        check("reset_async", seg, 3'b000);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("reset_held", seg, 3'b000);
        end

`ifdef AMPLIFICADOR_RAMP_EN
        // Test 3: release reset with A=B=1 already applied; the code ramps up from 000.
        rst_n = 1'b1;
        ramp_window("ramp_up", 20, 3'b000, 3'b001, 3'b011, 3'b111);

        // Test 4: ramp down from level 3 to 0, one level every 4 cycles.
        A = 1'b0; B = 1'b0;
        ramp_window("ramp_down", 20, 3'b111, 3'b011, 3'b001, 3'b000);

        // Test 5: ramp toward 3, then retarget to 1 while the level is 2.
        // The input change at edge 9 reaches the target at edge 12.
        // The prescaler keeps counting, so the level steps down at edge 15.
        // The output therefore shows 001 from edge 16 on.
        A = 1'b1; B = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            check($sformatf("retarget k=%0d", k), seg,
                  (k < 8) ? 3'b001 - 3'b001 : (k < 12) ? 3'b001 : (k < 16) ? 3'b011 : 3'b001);
            if (k == 9) begin
                A = 1'b0; B = 1'b1;
            end
        end

        // Return to level 0 before the reset test.
        A = 1'b0; B = 1'b0;
        repeat (30) @(negedge clk);
        check("settle_zero", seg, 3'b000);

        // Test 6: assert reset while the ramp is at level 2.
        A = 1'b1; B = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            check($sformatf("pre_reset k=%0d", k), seg,
                  (k < 8) ? 3'b000 : (k < 12) ? 3'b001 : 3'b011);
        end
        #2 rst_n = 1'b0;
        #1 check("midramp_reset_async", seg, 3'b000);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("midramp_reset_held", seg, 3'b000);
        end
        rst_n = 1'b1;
        ramp_window("ramp_after_reset", 20, 3'b000, 3'b001, 3'b011, 3'b111);
`else
        // Release reset with A=B=0. The outputs stay at 000.
        A = 1'b0; B = 1'b0;
        rst_n = 1'b1;
        step_window("idle_00", 10, 3'b000, 3'b000);

        // Test 2: sweep the gain code. Each new code appears 4 cycles after the change.
        A = 1'b0; B = 1'b1;
        step_window("sweep_01", 20, 3'b000, 3'b001);
        A = 1'b1; B = 1'b0;
        step_window("sweep_10", 20, 3'b001, 3'b011);
        A = 1'b1; B = 1'b1;
        step_window("sweep_11", 20, 3'b011, 3'b111);

        // Boundary case: a jump from the top level straight to 0 has no intermediate values.
        A = 1'b0; B = 1'b0;
        step_window("drop_00", 10, 3'b111, 3'b000);
        A = 1'b1; B = 1'b0;
        step_window("jump_10", 10, 3'b000, 3'b011);

        // Asynchronous reset in the middle of a clock cycle while at level 2.
        #2 rst_n = 1'b0;
        #1 check("run_reset_async", seg, 3'b000);
        @(negedge clk);
        check("run_reset_held", seg, 3'b000);
        rst_n = 1'b1;
        step_window("after_reset", 10, 3'b000, 3'b011);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
